// File: rtl/defs_pkg.sv
// rtl/defs_pkg.sv - decode, scoreboard and hazard-control types shared by the ID stage
package defs;

  typedef logic [4:0] reg_addr_t;

  typedef enum logic [6:0] {
    LOAD           = 7'h03,
    ARITHMETIC_IMM = 7'h13,
    AUIPC          = 7'h17,
    STORE          = 7'h23,
    ARITHMETIC_REG = 7'h33,
    LUI            = 7'h37,
    BRANCH         = 7'h63,
    JALR           = 7'h67,
    JAL            = 7'h6f
  } opcode_t;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;

  typedef enum logic [1:0] {
    CS_RUN   = 2'd0,
    CS_STALL = 2'd1,
    CS_FLUSH = 2'd2,
    CS_HOLD  = 2'd3
  } ctrl_state_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    logic      is_load;
  } sb_entry_t;

  // Opcodes outside the table read no sources and write no destination.
  function automatic logic writes_rd(opcode_t op);
    case (op)
      LOAD, ARITHMETIC_IMM, ARITHMETIC_REG, JAL, JALR, AUIPC, LUI: writes_rd = 1'b1;
      default: writes_rd = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs1(opcode_t op);
    case (op)
      LOAD, STORE, BRANCH, JALR, ARITHMETIC_IMM, ARITHMETIC_REG: uses_rs1 = 1'b1;
      default: uses_rs1 = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(opcode_t op);
    case (op)
      STORE, ARITHMETIC_REG, BRANCH: uses_rs2 = 1'b1;
      default: uses_rs2 = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - EX/MEM/WB destination scoreboard, RAW match and forward selects
// Build option FORWARD_EN: load-use-only stalls plus registered EX operand forwarding.
module hazard_scoreboard
  import defs::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      advance,
  input  logic      issue,
  input  opcode_t   op,
  input  reg_addr_t rd,
  input  reg_addr_t rs1,
  input  reg_addr_t rs2,
  output logic      raw_stall,
  output fwd_sel_t  fwd_rs1,
  output fwd_sel_t  fwd_rs2
);

  sb_entry_t ex_q, mem_q, wb_q, ex_d;
  logic      use1, use2;
  logic      ex_m1, ex_m2, mem_m1, mem_m2;
  logic      unused_sb;

  always_comb begin
    use1   = uses_rs1(op);
    use2   = uses_rs2(op);
    ex_m1  = ex_q.valid && use1 && (ex_q.rd == rs1);
    ex_m2  = ex_q.valid && use2 && (ex_q.rd == rs2);
    mem_m1 = mem_q.valid && use1 && (mem_q.rd == rs1);
    mem_m2 = mem_q.valid && use2 && (mem_q.rd == rs2);
    ex_d   = '0;
    if (issue) begin
      ex_d.valid   = writes_rd(op) && (rd != '0);
      ex_d.rd      = rd;
      ex_d.is_load = (op == LOAD);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (advance) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= ex_d;
    end
  end

  // The register file writes through, so the WB slot never feeds a decision.
  assign unused_sb = ^{wb_q, mem_q.is_load, ex_q.is_load};

`ifdef FORWARD_EN
  function automatic fwd_sel_t pick(logic ex_hit, logic ex_load, logic mem_hit);
    if (ex_hit && !ex_load) pick = FWD_EXMEM;
    else if (mem_hit)       pick = FWD_MEMWB;
    else                    pick = FWD_REG;
  endfunction

  assign raw_stall = ex_q.is_load && (ex_m1 || ex_m2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_rs1 <= FWD_REG;
      fwd_rs2 <= FWD_REG;
    end else if (advance) begin
      fwd_rs1 <= issue ? pick(ex_m1, ex_q.is_load, mem_m1) : FWD_REG;
      fwd_rs2 <= issue ? pick(ex_m2, ex_q.is_load, mem_m2) : FWD_REG;
    end
  end
`else
  assign raw_stall = ex_m1 || ex_m2 || mem_m1 || mem_m2;
  assign fwd_rs1   = FWD_REG;
  assign fwd_rs2   = FWD_REG;
`endif

endmodule

// File: rtl/id_hazard_ctrl.sv
// rtl/id_hazard_ctrl.sv - decode-stage hazard controller: stall/flush/hold priority and counters
// Build option FORWARD_EN selects the forwarding scoreboard variant.
module id_hazard_ctrl
  import defs::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  opcode_t          op_i,
  input  reg_addr_t        rd_i,
  input  reg_addr_t        rs1_i,
  input  reg_addr_t        rs2_i,
  input  logic             redirect_i,
  input  logic             hold_i,
  output logic             pc_en_o,
  output logic             ifid_en_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             pipe_en_o,
  output fwd_sel_t         fwd_rs1_o,
  output fwd_sel_t         fwd_rs2_o,
  output ctrl_state_t      ctrl_state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] hold_cnt_o
);

  ctrl_state_t state_q, state_d;
  logic        sb_raw, raw_stall, issue;

  hazard_scoreboard u_sb (
    .clk      (clk_i),
    .rst      (rst_i),
    .advance  (pipe_en_o),
    .issue    (issue),
    .op       (op_i),
    .rd       (rd_i),
    .rs1      (rs1_i),
    .rs2      (rs2_i),
    .raw_stall(sb_raw),
    .fwd_rs1  (fwd_rs1_o),
    .fwd_rs2  (fwd_rs2_o)
  );

  // Decoded fields of an empty IF/ID slot are meaningless, so they never stall.
  assign raw_stall = id_valid_i && sb_raw;
  assign issue     = id_valid_i && (state_d == CS_RUN);
  assign pipe_en_o = !hold_i;

  always_comb begin
    state_d = CS_RUN;
    if (hold_i)          state_d = CS_HOLD;
    else if (redirect_i) state_d = CS_FLUSH;
    else if (raw_stall)  state_d = CS_STALL;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= CS_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    pc_en_o       = 1'b1;
    ifid_en_o     = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    case (state_d)
      CS_HOLD: begin
        pc_en_o   = 1'b0;
        ifid_en_o = 1'b0;
      end
      CS_FLUSH: begin
        ifid_flush_o  = 1'b1;
        idex_bubble_o = 1'b1;
      end
      CS_STALL: begin
        pc_en_o       = 1'b0;
        ifid_en_o     = 1'b0;
        idex_bubble_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign ctrl_state_o = state_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
      hold_cnt_o  <= '0;
    end else begin
      if (state_d == CS_STALL && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (state_d == CS_FLUSH && flush_cnt_o != '1) flush_cnt_o <= flush_cnt_o + CNT_W'(1);
      if (state_d == CS_HOLD && hold_cnt_o != '1)   hold_cnt_o  <= hold_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb/tb_id_hazard_ctrl.sv - directed vector table plus randomized reference-model check of id_hazard_ctrl
module tb_id_hazard_ctrl;
  import defs::*;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam logic [4:0] EN_RUN = 5'b11001, EN_STALL = 5'b00011;
  localparam logic [4:0] EN_FLUSH = 5'b11111, EN_HOLD = 5'b00000;

  logic clk = 1'b0, rst = 1'b1;
  logic v_in = 1'b0, redir_in = 1'b0, hold_in = 1'b0;
  opcode_t op_in = ARITHMETIC_IMM;
  reg_addr_t rd_in = '0, rs1_in = '0, rs2_in = '0;
  logic pc_en, ifid_en, ifid_flush, idex_bubble, pipe_en;
  fwd_sel_t fwd1, fwd2;
  ctrl_state_t cstate;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, hold_cnt;

  int errors = 0, checks = 0;

  id_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(v_in), .op_i(op_in),
    .rd_i(rd_in), .rs1_i(rs1_in), .rs2_i(rs2_in),
    .redirect_i(redir_in), .hold_i(hold_in),
    .pc_en_o(pc_en), .ifid_en_o(ifid_en), .ifid_flush_o(ifid_flush),
    .idex_bubble_o(idex_bubble), .pipe_en_o(pipe_en),
    .fwd_rs1_o(fwd1), .fwd_rs2_o(fwd2), .ctrl_state_o(cstate),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt), .hold_cnt_o(hold_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v; opcode_t op; int rd, rs1, rs2; logic redir, hold;
    logic [4:0] en; fwd_sel_t f1, f2; ctrl_state_t st;
  } vec_t;

  typedef struct { int rd; bit ld; } inflight_t;

  vec_t tbl[14];
  inflight_t flight[$];
  int m_f1, m_f2, m_st, m_stall, m_flush, m_hold;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t row(logic v, opcode_t op, int rd, int rs1, int rs2, logic redir,
                               logic hold, logic [4:0] en, fwd_sel_t f1, fwd_sel_t f2,
                               ctrl_state_t st);
    vec_t r;
    r.v = v; r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.redir = redir; r.hold = hold;
    r.en = en; r.f1 = f1; r.f2 = f2; r.st = st;
    return r;
  endfunction

  task automatic drive(input logic v, input opcode_t op, input int rd, input int rs1,
                       input int rs2, input logic redir, input logic hold);
    v_in = v; op_in = op; rd_in = 5'(rd); rs1_in = 5'(rs1); rs2_in = 5'(rs2);
    redir_in = redir; hold_in = hold;
  endtask

  task automatic chk_en(input string tag, input logic [4:0] en);
    chk({tag, " pc_en"}, pc_en, en[4]);
    chk({tag, " ifid_en"}, ifid_en, en[3]);
    chk({tag, " ifid_flush"}, ifid_flush, en[2]);
    chk({tag, " idex_bubble"}, idex_bubble, en[1]);
    chk({tag, " pipe_en"}, pipe_en, en[0]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, ARITHMETIC_IMM, 0, 0, 0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference: a source hits the instruction issued k advancing cycles ago.
  function automatic bit hit(int k, int rs, bit used);
    return used && flight[k].rd != 0 && flight[k].rd == rs;
  endfunction

  function automatic int fsel(int rs, bit used, bit iss);
    if (!iss) return int'(FWD_REG);
    if (hit(0, rs, used) && !flight[0].ld) return int'(FWD_EXMEM);
    if (hit(1, rs, used)) return int'(FWD_MEMWB);
    return int'(FWD_REG);
  endfunction

  initial begin
`ifdef FORWARD_EN
    tbl[0]  = row(1, ARITHMETIC_IMM, 3, 0, 0, 0, 0, EN_RUN, FWD_REG, FWD_REG, CS_RUN);
    tbl[1]  = row(1, ARITHMETIC_REG, 4, 3, 3, 0, 0, EN_RUN, FWD_EXMEM, FWD_EXMEM, CS_RUN);
    tbl[2]  = row(1, ARITHMETIC_IMM, 0, 0, 0, 0, 0, EN_RUN, FWD_REG, FWD_REG, CS_RUN);
    tbl[3]  = row(1, ARITHMETIC_REG, 7, 0, 0, 0, 0, EN_RUN, FWD_REG, FWD_REG, CS_RUN);
    tbl[4]  = row(1, LOAD, 5, 1, 0, 0, 0, EN_RUN, FWD_REG, FWD_REG, CS_RUN);
    tbl[5]  = row(1, ARITHMETIC_REG, 6, 5, 2, 0, 0, EN_STALL, FWD_REG, FWD_REG, CS_STALL);
    tbl[6]  = row(1, ARITHMETIC_REG, 6, 5, 2, 0, 0, EN_RUN, FWD_MEMWB, FWD_REG, CS_RUN);
    tbl[7]  = row(1, ARITHMETIC_REG, 8, 6, 6, 0, 1, EN_HOLD, FWD_MEMWB, FWD_REG, CS_HOLD);
    tbl[8]  = row(1, ARITHMETIC_REG, 8, 6, 6, 0, 1, EN_HOLD, FWD_MEMWB, FWD_REG, CS_HOLD);
    tbl[9]  = row(1, ARITHMETIC_REG, 8, 6, 6, 1, 1, EN_HOLD, FWD_MEMWB, FWD_REG, CS_HOLD);
    tbl[10] = row(1, ARITHMETIC_REG, 8, 6, 6, 0, 0, EN_RUN, FWD_EXMEM, FWD_EXMEM, CS_RUN);
    tbl[11] = row(1, LOAD, 5, 1, 0, 0, 0, EN_RUN, FWD_REG, FWD_REG, CS_RUN);
    tbl[12] = row(1, ARITHMETIC_REG, 6, 5, 2, 1, 0, EN_FLUSH, FWD_REG, FWD_REG, CS_FLUSH);
    tbl[13] = row(0, ARITHMETIC_IMM, 0, 0, 0, 0, 0, EN_RUN, FWD_REG, FWD_REG, CS_RUN);
`else
    tbl[0]  = row(1, ARITHMETIC_IMM, 3, 0, 0, 0, 0, EN_RUN, FWD_REG, FWD_REG, CS_RUN);
    tbl[1]  = row(1, ARITHMETIC_REG, 4, 3, 3, 0, 0, EN_STALL, FWD_REG, FWD_REG, CS_STALL);
    tbl[2]  = row(1, ARITHMETIC_REG, 4, 3, 3, 0, 0, EN_STALL, FWD_REG, FWD_REG, CS_STALL);
    tbl[3]  = row(1, ARITHMETIC_REG, 4, 3, 3, 0, 0, EN_RUN, FWD_REG, FWD_REG, CS_RUN);
    tbl[4]  = row(1, ARITHMETIC_IMM, 0, 0, 0, 0, 0, EN_RUN, FWD_REG, FWD_REG, CS_RUN);
    tbl[5]  = row(1, ARITHMETIC_REG, 7, 0, 0, 0, 0, EN_RUN, FWD_REG, FWD_REG, CS_RUN);
    tbl[6]  = row(1, LOAD, 5, 1, 0, 0, 0, EN_RUN, FWD_REG, FWD_REG, CS_RUN);
    tbl[7]  = row(1, ARITHMETIC_REG, 6, 5, 2, 1, 0, EN_FLUSH, FWD_REG, FWD_REG, CS_FLUSH);
    tbl[8]  = row(1, ARITHMETIC_REG, 6, 5, 2, 0, 1, EN_HOLD, FWD_REG, FWD_REG, CS_HOLD);
    tbl[9]  = row(1, ARITHMETIC_REG, 6, 5, 2, 0, 1, EN_HOLD, FWD_REG, FWD_REG, CS_HOLD);
    tbl[10] = row(1, ARITHMETIC_REG, 6, 5, 2, 1, 1, EN_HOLD, FWD_REG, FWD_REG, CS_HOLD);
    tbl[11] = row(1, ARITHMETIC_REG, 6, 5, 2, 0, 0, EN_STALL, FWD_REG, FWD_REG, CS_STALL);
    tbl[12] = row(1, ARITHMETIC_REG, 6, 5, 2, 0, 0, EN_RUN, FWD_REG, FWD_REG, CS_RUN);
    tbl[13] = row(0, ARITHMETIC_IMM, 0, 0, 0, 0, 0, EN_RUN, FWD_REG, FWD_REG, CS_RUN);
`endif

    do_reset();
    #1;
    chk_en("reset", EN_RUN);
    chk("reset fwd_rs1", fwd1, FWD_REG);
    chk("reset fwd_rs2", fwd2, FWD_REG);
    chk("reset ctrl_state", cstate, CS_RUN);
    chk("reset stall_cnt", stall_cnt, 0);
    chk("reset flush_cnt", flush_cnt, 0);
    chk("reset hold_cnt", hold_cnt, 0);

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].redir, tbl[i].hold);
      #1;
      chk_en($sformatf("row%0d", i), tbl[i].en);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d fwd_rs1", i), fwd1, tbl[i].f1);
      chk($sformatf("row%0d fwd_rs2", i), fwd2, tbl[i].f2);
      chk($sformatf("row%0d ctrl_state", i), cstate, tbl[i].st);
    end
`ifdef FORWARD_EN
    chk("table stall_cnt", stall_cnt, 1);
`else
    chk("table stall_cnt", stall_cnt, 3);
`endif
    chk("table flush_cnt", flush_cnt, 1);
    chk("table hold_cnt", hold_cnt, 3);

    // Asynchronous reset landing in the middle of a hold.
    @(negedge clk);
    drive(1'b1, ARITHMETIC_REG, 6, 5, 2, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async rst ctrl_state", cstate, CS_RUN);
    chk("async rst hold_cnt", hold_cnt, 0);
    chk("async rst flush_cnt", flush_cnt, 0);
    chk("async rst fwd_rs1", fwd1, FWD_REG);
    @(negedge clk);
    drive(1'b0, ARITHMETIC_IMM, 0, 0, 0, 1'b0, 1'b0);
    rst = 1'b0;

    for (int k = 0; k < 3; k++) flight.push_back('{rd: 0, ld: 0});
    m_f1 = int'(FWD_REG); m_f2 = int'(FWD_REG); m_st = int'(CS_RUN);
    m_stall = 0; m_flush = 0; m_hold = 0;

    for (int c = 0; c < 3000; c++) begin
      opcode_t ops[9];
      opcode_t op;
      bit v, redir, hold, u1, u2, wr, stall, iss;
      int rd, rs1, rs2, cls;
      ops = '{LOAD, STORE, BRANCH, JAL, JALR, ARITHMETIC_IMM, ARITHMETIC_REG, AUIPC, LUI};
      @(negedge clk);
      chk("rnd fwd_rs1", fwd1, m_f1);
      chk("rnd fwd_rs2", fwd2, m_f2);
      chk("rnd ctrl_state", cstate, m_st);
      chk("rnd stall_cnt", stall_cnt, m_stall);
      chk("rnd flush_cnt", flush_cnt, m_flush);
      chk("rnd hold_cnt", hold_cnt, m_hold);

      v = ($urandom_range(0, 7) != 0);
      op = ops[$urandom_range(0, 8)];
      if ($urandom_range(0, 9) == 0) op = opcode_t'(7'h73);
      rd = $urandom_range(0, 3); rs1 = $urandom_range(0, 3); rs2 = $urandom_range(0, 3);
      redir = ($urandom_range(0, 7) == 0);
      hold = ($urandom_range(0, 7) == 0);
      drive(v, op, rd, rs1, rs2, redir, hold);
      #1;

      u1 = op inside {LOAD, STORE, BRANCH, JALR, ARITHMETIC_IMM, ARITHMETIC_REG};
      u2 = op inside {STORE, ARITHMETIC_REG, BRANCH};
      wr = op inside {LOAD, ARITHMETIC_IMM, ARITHMETIC_REG, JAL, JALR, AUIPC, LUI};
`ifdef FORWARD_EN
      stall = v && flight[0].ld && (hit(0, rs1, u1) || hit(0, rs2, u2));
`else
      stall = v && (hit(0, rs1, u1) || hit(0, rs2, u2) || hit(1, rs1, u1) || hit(1, rs2, u2));
`endif
      cls = hold ? 3 : redir ? 2 : stall ? 1 : 0;
      chk("rnd pc_en", pc_en, cls == 0 || cls == 2);
      chk("rnd ifid_en", ifid_en, cls == 0 || cls == 2);
      chk("rnd ifid_flush", ifid_flush, cls == 2);
      chk("rnd idex_bubble", idex_bubble, cls == 1 || cls == 2);
      chk("rnd pipe_en", pipe_en, !hold);

      m_st = cls;
      if (cls == 1 && m_stall < CMAX) m_stall++;
      if (cls == 2 && m_flush < CMAX) m_flush++;
      if (cls == 3 && m_hold < CMAX) m_hold++;
      if (!hold) begin
        iss = v && cls == 0;
`ifdef FORWARD_EN
        m_f1 = fsel(rs1, u1, iss);
        m_f2 = fsel(rs2, u2, iss);
`endif
        flight.push_front('{rd: (iss && wr) ? rd : 0, ld: iss && op == LOAD});
        void'(flight.pop_back());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_hazard_ctrl.md
# id_hazard_ctrl

Pipeline hazard controller for the 5-stage RV32I core. It sits beside the decode stage and consumes its decoded fields (opcode, rd, rs1, rs2). It keeps a 3-slot scoreboard of in-flight destination registers and drives the PC, IF/ID and ID/EX enables, bubbles and flushes. It also produces registered forwarding selects for the EX stage and per-class cycle counters.

## Interface
- CNT_W, 32, width of each performance counter
- clk_i  in  1  core clock
- rst_i  in  1  asynchronous, active-high reset
- id_valid_i  in  1  IF/ID holds a valid instruction
- op_i  in  opcode_t  decoded opcode
- rd_i, rs1_i, rs2_i  in  reg_addr_t  decoded register fields
- redirect_i  in  1  EX resolved a taken branch/JAL/JALR this cycle
- hold_i  in  1  data-memory wait; freeze entire pipeline
- pc_en_o  out  1  PC register enable
- ifid_en_o  out  1  IF/ID register enable
- ifid_flush_o  out  1  IF/ID loads NOP at next edge
- idex_bubble_o  out  1  ID/EX loads NOP at next edge
- pipe_en_o  out  1  ID/EX, EX/MEM, MEM/WB enable (= !hold_i)
- fwd_rs1_o, fwd_rs2_o  out  fwd_sel_t (2)  registered operand source for the instruction in EX
- ctrl_state_o  out  ctrl_state_t (2)  class of the previous cycle
- stall_cnt_o, flush_cnt_o, hold_cnt_o  out  CNT_W  saturating cycle counters

## Operation
- Scoreboard slots EX, MEM, WB; each holds {valid, rd, is_load}.
- Issue: the instruction in ID issues when id_valid_i is set and it is not stalled, flushed or held.
- On issue, the EX slot is loaded with valid = writes_rd && rd_i != 0, rd = rd_i, is_load = (op_i == LOAD). Otherwise the EX slot loads invalid.
- writes_rd: LOAD, ARITHMETIC_IMM, ARITHMETIC_REG, JAL, JALR, AUIPC, LUI.
- uses_rs1: every opcode except JAL, AUIPC, LUI. uses_rs2: STORE, ARITHMETIC_REG, BRANCH. Unknown opcode: no rd, no sources.
- Slots shift EX→MEM→WB on every cycle with !hold_i. The WB slot is discarded after that cycle; the register file writes through.
- A match means the slot is valid, uses_rsX is set and the slot rd equals rsX.
- raw_stall (FORWARD_EN): the EX slot is a load and it matches rs1 or rs2.
- raw_stall (no FORWARD_EN): the EX or MEM slot matches rs1 or rs2.
- Priority, highest first: rst_i > hold_i > redirect_i > raw_stall > run.
  - hold_i: pc_en_o, ifid_en_o, pipe_en_o = 0; bubble/flush = 0; scoreboard frozen.
  - redirect_i: ifid_flush_o = 1, idex_bubble_o = 1, pc_en_o = 1; EX slot loads invalid.
  - raw_stall: pc_en_o = ifid_en_o = 0, idex_bubble_o = 1; EX slot loads invalid.
  - run: all enables 1, no bubble or flush.
- Forward selects are computed in ID and registered on issue, then held while hold_i is set.
  - FWD_EXMEM: the EX slot matches and is not a load.
  - FWD_MEMWB: the MEM slot matches.
  - FWD_REG: neither of the above. If both the EX and MEM slots match, EX wins.
  - On a bubble or flush, both selects register FWD_REG.
- ctrl_state_o registers the cycle class: RUN=0, STALL=1, FLUSH=2, HOLD=3.
- Counters increment on the matching class at each edge and saturate at all-ones.

## Timing
- Reset values: all scoreboard slots invalid, fwd_* = FWD_REG, ctrl_state_o = RUN, all counters 0. Reset is asynchronous and may assert mid-stall or mid-hold; the result is the same clean state.
- pc_en_o, ifid_en_o, ifid_flush_o, idex_bubble_o and pipe_en_o are combinational from the inputs and scoreboard, with zero latency.
- fwd_*, ctrl_state_o and the counters have 1-cycle latency.
- Load-use costs exactly 1 stall cycle with FORWARD_EN; dependent ALU ops cost 0. Without FORWARD_EN, a distance-1 dependency costs 2 stall cycles and distance-2 costs 1.
- redirect_i together with raw_stall: the flush wins and no stall is counted.
- hold_i together with redirect_i: hold wins. EX must keep redirect_i asserted until hold_i drops.
- Counter at all-ones plus another event: the value stays at all-ones.

## Configuration
- FORWARD_EN defined: forwarding logic is present and the load-use-only stall rule applies.
- FORWARD_EN undefined: fwd_rs1_o and fwd_rs2_o are tied to FWD_REG, the EX/MEM-slot stall rule applies, and no forwarding muxes are needed downstream.

## Structure
- defs package: fwd_sel_t (FWD_REG, FWD_EXMEM, FWD_MEMWB), ctrl_state_t, sb_entry_t {valid, rd, is_load}.
- Existing opcode_t, reg_addr_t and LOAD..LUI come from defs.
- One sub-module, hazard_scoreboard: the 3-slot shift register plus match and forward-select logic. The parent holds the priority logic, the state register and the counters.

## Test plan
- Load-use: lw x5,0(x1) then add x6,x5,x2 → one cycle with pc_en_o=0 and idex_bubble_o=1; the add gets fwd_rs1_o=FWD_MEMWB; stall_cnt_o=1.
- ALU chain: addi x3,x0,1 then add x4,x3,x3 → no stall; both fwd selects = FWD_EXMEM.
- rd=x0: addi x0,x0,5 then add x7,x0,x0 → no stall; fwd = FWD_REG.
- Redirect during stall: redirect_i=1 in the same cycle as a load-use match → ifid_flush_o=1, flush_cnt_o+1, stall_cnt_o unchanged.
- Hold: hold_i high for 3 cycles mid-sequence → all enables 0, scoreboard and fwd unchanged, hold_cnt_o=3.
- Without FORWARD_EN: addi x3 then add x4,x3 → 2 stall cycles; fwd always FWD_REG.
